framebuffer_fetch: RTL and testbench



---
 rtl/led_display_pkg.sv | 34 +++
 rtl/line_buffer_pingpong.sv | 22 ++
 rtl/framebuffer_fetch.sv | 167 ++++++++++++++++
 tb/tb_framebuffer_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared constants, fetch FSM state type and the RGB565 expansion helper for the LED panel datapath.
// The ram_addr width follows DOUBLE_BUFFER_EN: with the macro a frame-select bit is prepended.
package led_display_pkg;
  localparam int COLUMNS         = 64;
  localparam int COL_BITS        = 6;
  localparam int ROW_BITS        = 4;
  localparam int BRIGHTNESS_BITS = 6;
  localparam int LB_DEPTH        = 2 * COLUMNS;
  localparam int R_LSB           = 11;
  localparam int G_LSB           = 5;
  localparam int B_LSB           = 0;
`ifdef DOUBLE_BUFFER_EN
  localparam int RAM_AW          = 12;
`else
  localparam int RAM_AW          = 11;
`endif

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb666_t;

  // 5-bit channels replicate their MSB into the new LSB
  function automatic rgb666_t rgb565_to_rgb666(input logic [15:0] w);
    rgb666_t c;
    c.r = {w[R_LSB+:5], w[R_LSB+4]};
    c.g = w[G_LSB+:6];
    c.b = {w[B_LSB+:5], w[B_LSB+4]};
    return c;
  endfunction
endpackage

// File: rtl/line_buffer_pingpong.sv
// Two 128x16 line banks: one write port, one read port returning the top and bottom words of a column.
module line_buffer_pingpong
  import led_display_pkg::*;
(
  input  logic                clk_in,
  input  logic                i_we,
  input  logic                i_wbank,
  input  logic [COL_BITS:0]   i_waddr,
  input  logic [15:0]         i_wdata,
  input  logic                i_rbank,
  input  logic [COL_BITS-1:0] i_rcol,
  output logic [15:0]         o_top,
  output logic [15:0]         o_bottom
);
  logic [15:0] r_mem [2][LB_DEPTH];

  always_ff @(posedge clk_in)
    if (i_we) r_mem[i_wbank][i_waddr] <= i_wdata;

  assign o_top    = r_mem[i_rbank][{1'b0, i_rcol}];
  assign o_bottom = r_mem[i_rbank][{1'b1, i_rcol}];
endmodule

// File: rtl/framebuffer_fetch.sv
// Prefetches row-pairs from framebuffer RAM into a ping-pong line buffer and serves bit-plane pixels.
// Optional DOUBLE_BUFFER_EN adds frame_swap_req/frame_sel and a frame bit on ram_addr.
module framebuffer_fetch
  import led_display_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [ROW_BITS-1:0]        row_address,
  input  logic [COL_BITS-1:0]        column_address,
  input  logic [BRIGHTNESS_BITS-1:0] brightness_mask,
  input  logic                       pixel_load_en,
`ifdef DOUBLE_BUFFER_EN
  input  logic                       frame_swap_req,
  output logic                       frame_sel,
`endif
  output logic [RAM_AW-1:0]          ram_addr,
  output logic                       ram_rd_en,
  input  logic [15:0]                ram_data,
  output logic [2:0]                 rgb_top,
  output logic [2:0]                 rgb_bottom,
  output logic                       fetch_busy,
  output logic                       underrun
);
  localparam int DCW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  fetch_state_e r_state, w_next;
  logic [COL_BITS:0]   r_cnt;
  logic [DCW-1:0]      r_dcnt;
  logic                r_tgt_bank, r_req, r_req_bank, r_active, r_underrun;
  logic [ROW_BITS-1:0] r_tgt_row, r_req_row, r_row_prev;
  logic [1:0]          r_valid;
  logic [2:0]          r_rgb_top, r_rgb_bot;
  logic [RAM_LATENCY-1:0]             r_pv;
  logic [RAM_LATENCY-1:0][COL_BITS+1:0] r_pa;
  logic        w_drain_end, w_done, w_abort, w_row_chg, w_new_vld;
  logic [15:0] w_lb_top, w_lb_bot;
  rgb666_t     w_top, w_bot;

  assign w_drain_end = (r_state == DRAIN) && (r_dcnt == DCW'(RAM_LATENCY - 1));
  assign w_done      = w_drain_end && !r_req;
  assign w_abort     = r_req && (r_state != IDLE);
  assign w_row_chg   = row_address != r_row_prev;
  // a fetch finishing on the swap edge still counts for the newly active bank
  assign w_new_vld   = r_valid[~r_active] | (w_done && (r_tgt_bank == ~r_active));

  always_ff @(posedge clk_in)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_req) w_next = FILL;
      FILL:    if (r_req) w_next = FILL;
               else if (r_cnt == '1) w_next = DRAIN;
      DRAIN:   if (r_req) w_next = FILL;
               else if (w_drain_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ram_rd_en  = (r_state == FILL) && !reset;
    fetch_busy = (r_state != IDLE) && !reset;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt <= '0; r_dcnt <= '0; r_tgt_bank <= 1'b0; r_tgt_row <= '0;
    end else begin
      if (r_req) begin
        r_cnt <= '0; r_tgt_bank <= r_req_bank; r_tgt_row <= r_req_row;
      end else if (r_state == FILL) r_cnt <= r_cnt + 1'b1;
      r_dcnt <= (r_state == DRAIN && !r_req) ? r_dcnt + 1'b1 : '0;
    end
  end

  // Return-data address pipe; an abort flushes reads still in flight
  always_ff @(posedge clk_in) begin
    if (reset || w_abort) begin
      r_pv <= '0; r_pa <= '0;
    end else begin
      for (int i = RAM_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1]; r_pa[i] <= r_pa[i-1];
      end
      r_pv[0] <= ram_rd_en;
      r_pa[0] <= {r_tgt_bank, r_cnt};
    end
  end

  // Bank bookkeeping: a row change always restarts the engine; idle fills the active bank first
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_active <= 1'b0; r_valid <= '0; r_row_prev <= row_address; r_underrun <= 1'b0;
      r_req <= 1'b0; r_req_bank <= 1'b0; r_req_row <= '0;
    end else begin
      if (w_done) r_valid[r_tgt_bank] <= 1'b1;
      if (w_row_chg) begin
        r_active          <= ~r_active;
        r_row_prev        <= row_address;
        r_valid[r_active] <= 1'b0;
        r_req             <= 1'b1;
        if (w_new_vld) begin
          r_req_bank <= r_active;  r_req_row <= row_address + 1'b1;
        end else begin
          r_underrun <= 1'b1;
          r_req_bank <= ~r_active; r_req_row <= row_address;
        end
      end else if (r_req) begin
        r_req <= 1'b0;
      end else if (r_state == IDLE && !r_valid[r_active]) begin
        r_req <= 1'b1; r_req_bank <= r_active;  r_req_row <= r_row_prev;
      end else if (r_state == IDLE && !r_valid[~r_active]) begin
        r_req <= 1'b1; r_req_bank <= ~r_active; r_req_row <= r_row_prev + 1'b1;
      end
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic r_frame, r_swap_pend;
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_frame <= 1'b0; r_swap_pend <= 1'b0;
    end else if (r_swap_pend && w_row_chg && row_address == '0) begin
      r_frame <= ~r_frame; r_swap_pend <= 1'b0;
    end else if (frame_swap_req) r_swap_pend <= 1'b1;
  end
  assign frame_sel = r_frame;
  assign ram_addr  = {r_frame, r_cnt[COL_BITS], r_tgt_row, r_cnt[COL_BITS-1:0]};
`else
  assign ram_addr  = {r_cnt[COL_BITS], r_tgt_row, r_cnt[COL_BITS-1:0]};
`endif

  line_buffer_pingpong u_lb (
    .clk_in   (clk_in),
    .i_we     (r_pv[RAM_LATENCY-1] && !r_req),
    .i_wbank  (r_pa[RAM_LATENCY-1][COL_BITS+1]),
    .i_waddr  (r_pa[RAM_LATENCY-1][COL_BITS:0]),
    .i_wdata  (ram_data),
    .i_rbank  (r_active),
    .i_rcol   (column_address),
    .o_top    (w_lb_top),
    .o_bottom (w_lb_bot)
  );

  assign w_top = rgb565_to_rgb666(w_lb_top);
  assign w_bot = rgb565_to_rgb666(w_lb_bot);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rgb_top <= '0; r_rgb_bot <= '0;
    end else if (pixel_load_en) begin
      if (r_valid[r_active]) begin
        r_rgb_top <= {|(w_top.r & brightness_mask), |(w_top.g & brightness_mask), |(w_top.b & brightness_mask)};
        r_rgb_bot <= {|(w_bot.r & brightness_mask), |(w_bot.g & brightness_mask), |(w_bot.b & brightness_mask)};
      end else begin
        r_rgb_top <= '0; r_rgb_bot <= '0;
      end
    end
  end

  assign rgb_top    = r_rgb_top;
  assign rgb_bottom = r_rgb_bot;
  assign underrun   = r_underrun;
endmodule

// File: tb/tb_framebuffer_fetch.sv
// Self-checking bench for framebuffer_fetch: RAM model, pixel scoreboard, fetch/abort/wrap scenarios.
// Build with DOUBLE_BUFFER_EN to also exercise the frame-swap path.
module tb_framebuffer_fetch;
  import led_display_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, ld, ram_rd_en, fetch_busy, underrun;
  logic [3:0]        row;
  logic [5:0]        col, mask;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_data = 16'h0;
  logic [2:0]        rgb_top, rgb_bottom;
`ifdef DOUBLE_BUFFER_EN
  logic swap_req = 1'b0, frame_sel;
`endif

  int total = 0, bad = 0;
  logic [15:0]       mem [2048];
  logic [RAM_AW-1:0] addr_log [$];
  logic [5:0]        exp_q [$];
  logic [5:0]        last_exp;

  framebuffer_fetch #(.RAM_LATENCY(1)) dut (
    .clk_in(clk), .reset(reset), .row_address(row), .column_address(col),
    .brightness_mask(mask), .pixel_load_en(ld),
`ifdef DOUBLE_BUFFER_EN
    .frame_swap_req(swap_req), .frame_sel(frame_sel),
`endif
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
    .rgb_top(rgb_top), .rgb_bottom(rgb_bottom), .fetch_busy(fetch_busy), .underrun(underrun));

  // one-cycle-latency framebuffer RAM; frame bit ignored by the contents
  always @(posedge clk)
    if (ram_rd_en) begin
      ram_data <= mem[ram_addr[10:0]];
      addr_log.push_back(ram_addr);
    end

  function automatic logic [2:0] ebits(input logic [15:0] w, input logic [5:0] m);
    logic [5:0] r6, g6, b6;
    r6 = {w[15:11], w[15]};
    g6 = w[10:5];
    b6 = {w[4:0], w[4]};
    return {|(r6 & m), |(g6 & m), |(b6 & m)};
  endfunction

  function automatic int aidx(input int half, input int r, input int c);
    return (half << 10) | (r << 6) | c;
  endfunction

  task automatic pix(input int r, input int c, input logic [5:0] m, input bit vis, input string nm);
    logic [5:0] e;
    exp_q.push_back(vis ? {ebits(mem[aidx(0, r, c)], m), ebits(mem[aidx(1, r, c)], m)} : 6'd0);
    @(negedge clk); col = 6'(c); mask = m; ld = 1'b1;
    @(posedge clk); #1; ld = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    total++;
    if ({rgb_top, rgb_bottom} !== e) begin
      bad++;
      $display("FAIL %s: row %0d col %0d mask %b got top=%b bot=%b want top=%b bot=%b",
               nm, r, c, m, rgb_top, rgb_bottom, e[5:3], e[2:0]);
    end
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0, n = 0;
    repeat (3) @(negedge clk);
    while (quiet < 4 && n < 2000) begin
      @(negedge clk); n++;
      quiet = fetch_busy ? 0 : quiet + 1;
    end
    total++;
    if (quiet < 4) begin bad++; $display("FAIL %s: fetch still busy after %0d cycles", nm, n); end
  endtask

  task automatic set_row(input int r);
    @(negedge clk); row = 4'(r);
  endtask

  task automatic test_reset();
    int n = 0, busy = 0;
    reset = 1'b1; row = 0; col = 0; mask = 0; ld = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({rgb_top, rgb_bottom, ram_rd_en, fetch_busy, underrun} !== 9'd0 || ram_addr !== '0) begin
      bad++; $display("FAIL reset_state: rgb=%b/%b rd=%b busy=%b unr=%b addr=%h want all 0",
                      rgb_top, rgb_bottom, ram_rd_en, fetch_busy, underrun, ram_addr);
    end
    addr_log.delete();
    reset = 1'b0;
    while (!fetch_busy && n < 10) begin @(negedge clk); n++; end
    while (fetch_busy && busy < 400) begin busy++; @(negedge clk); end
    total++;
    if (busy != 129) begin bad++; $display("FAIL first_fetch_len: busy %0d cycles want 129", busy); end
    wait_idle("initial_prefetch");
    total++;
    if (addr_log.size() != 256) begin
      bad++; $display("FAIL initial_read_count: got %0d reads want 256", addr_log.size());
    end else begin
      int errs = 0;
      for (int i = 0; i < 256; i++)
        if (addr_log[i] !== RAM_AW'(aidx((i / 64) % 2, i / 128, i % 64))) errs++;
      if (errs != 0) begin bad++; $display("FAIL initial_addr_seq: %0d wrong addresses want 0", errs); end
    end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL initial_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_pixel();
    pix(0, 0, 6'b100000, 1, "red_plane");
    total++;
    if (rgb_top !== 3'b100) begin bad++; $display("FAIL red_top: got %b want 100", rgb_top); end
    pix(0, 0, 6'b000000, 1, "blank_mask");
    total++;
    if (rgb_top !== 3'b000) begin bad++; $display("FAIL blank_top: got %b want 000", rgb_top); end
  endtask

  task automatic test_mask_sweep();
    for (int i = 0; i < 6; i++) begin
      logic [5:0] m;
      m = 6'b100000 >> i;
      pix(0, 1, m, 1, "g_sweep");
      total++;
      if (rgb_top[1] !== (i == 5)) begin
        bad++; $display("FAIL g_bit: mask %b got g=%b want %b", m, rgb_top[1], (i == 5));
      end
    end
  endtask

  task automatic test_hold();
    pix(0, 1, 6'b000010, 1, "hold_setup");
    @(negedge clk); col = 6'd9; mask = 6'b111111;
    repeat (3) @(negedge clk);
    total++;
    if ({rgb_top, rgb_bottom} !== last_exp) begin
      bad++; $display("FAIL hold: got %b%b want %b", rgb_top, rgb_bottom, last_exp);
    end
  endtask

  task automatic test_row_change();
    int n = 0;
    addr_log.delete();
    set_row(1);
    while (!fetch_busy && n < 5) begin @(negedge clk); n++; end
    total++;
    if (!fetch_busy) begin bad++; $display("FAIL prefetch_start: busy=%b want 1", fetch_busy); end
    for (int i = 0; i < 4; i++) pix(1, $urandom_range(63), 6'b000001 << $urandom_range(5), 1, "row1_pixels");
    wait_idle("row2_prefetch");
    total++;
    if (addr_log.size() < 1 || addr_log[0] !== RAM_AW'(aidx(0, 2, 0))) begin
      bad++; $display("FAIL row2_first_addr: got %h want %h", addr_log.size() ? addr_log[0] : '1, aidx(0, 2, 0));
    end
    total++;
    if (underrun !== 1'b0) begin bad++; $display("FAIL row_change_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_underrun();
    set_row(2);
    pix(2, 3, 6'b000100, 1, "row2_visible");
    repeat (20) @(negedge clk);
    addr_log.delete();
    set_row(3);
    @(negedge clk);
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set: got %b want 1", underrun); end
    pix(3, 5, 6'b111111, 0, "blank_during_underrun");
    pix(3, 40, 6'b100000, 0, "blank_during_underrun");
    wait_idle("row3_refetch");
    total++;
    if (addr_log.size() < 256 || addr_log[addr_log.size() - 256] !== RAM_AW'(aidx(0, 3, 0))) begin
      bad++; $display("FAIL refetch_row3: %0d reads, restart addr wrong", addr_log.size());
    end
    pix(3, 7, 6'b001000, 1, "row3_visible");
  endtask

  task automatic test_wrap();
    for (int r = 4; r < 16; r++) begin
      set_row(r);
      wait_idle("row_step");
    end
    pix(15, 63, 6'b010000, 1, "row15_visible");
    addr_log.delete();
    set_row(0);
    wait_idle("wrap_prefetch");
    total++;
    if (addr_log.size() < 1 || addr_log[0] !== RAM_AW'(aidx(0, 1, 0))) begin
      bad++; $display("FAIL wrap_target: first addr %h want %h", addr_log.size() ? addr_log[0] : '1, aidx(0, 1, 0));
    end
    pix(0, 0, 6'b100000, 1, "row0_after_wrap");
    total++;
    if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", underrun); end
  endtask

  task automatic test_reset_mid();
    set_row(1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (ram_rd_en !== 1'b0 || fetch_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_comb: rd=%b busy=%b want 0 0", ram_rd_en, fetch_busy);
    end
    @(posedge clk); #1;
    total++;
    if ({rgb_top, rgb_bottom, underrun} !== 7'd0 || ram_addr !== '0) begin
      bad++; $display("FAIL reset_mid_state: rgb=%b/%b unr=%b addr=%h want 0", rgb_top, rgb_bottom, underrun, ram_addr);
    end
    @(negedge clk); reset = 1'b0;
    wait_idle("post_reset_prefetch");
    pix(1, 17, 6'b000001, 1, "row1_after_reset");
  endtask

`ifdef DOUBLE_BUFFER_EN
  task automatic test_dbuf();
    set_row(7);
    wait_idle("row7_settle");
    @(negedge clk); swap_req = 1'b1;
    @(negedge clk); swap_req = 1'b0;
    repeat (3) @(negedge clk);
    swap_req = 1'b1; @(negedge clk); swap_req = 1'b0;
    total++;
    if (frame_sel !== 1'b0) begin bad++; $display("FAIL frame_hold: got %b want 0", frame_sel); end
    addr_log.delete();
    set_row(0);
    @(negedge clk);
    total++;
    if (frame_sel !== 1'b1) begin bad++; $display("FAIL frame_swap: got %b want 1", frame_sel); end
    wait_idle("dbuf_prefetch");
    total++;
    if (addr_log.size() < 1 || addr_log[0] !== RAM_AW'(12'h800 | aidx(0, 1, 0))) begin
      bad++; $display("FAIL dbuf_addr: got %h want %h", addr_log.size() ? addr_log[0] : '0, 12'h800 | aidx(0, 1, 0));
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {5'd0, 4'(i >> 6), 1'(i >> 10), 6'(i)};
    mem[aidx(0, 0, 0)] = 16'hF800;
    mem[aidx(0, 0, 1)] = 16'h0020;
    for (int c = 0; c < 64; c++) mem[aidx(0, 1, c)] = 16'($urandom);
    test_reset();
    test_pixel();
    test_mask_sweep();
    test_hold();
    test_row_change();
    test_underrun();
    test_wrap();
    test_reset_mid();
`ifdef DOUBLE_BUFFER_EN
    test_dbuf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
